// File: rtl/nios_system_gpio_in.sv
// Avalon-MM input PIO: pins are synchronised, debounced per bit, and qualifying
// edges of the debounced level are latched into a capture register that drives a maskable irq.
`timescale 1ns/1ps
module nios_system_gpio_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int IDLE_LEVEL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] RST_LEVEL = {WIDTH{(IDLE_LEVEL != 0)}};

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_capture_clr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr;
    logic             w_unused;

    assign w_wr     = chipselect && !write_n;
    assign w_wdata  = writedata[WIDTH-1:0];
    assign w_unused = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RST_LEVEL;
            r_sync2 <= RST_LEVEL;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // A bit is accepted when its synchronised level has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive edges.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (r_sync2[gi] == r_stable[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign w_accept[gi] = (r_sync2[gi] != r_stable[gi]) && (r_cnt == CNT_LAST);

            if (EDGE_TYPE == 0) begin : g_rise
                assign w_edge_set[gi] = w_accept[gi] && r_sync2[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign w_edge_set[gi] = w_accept[gi] && !r_sync2[gi];
            end else begin : g_any
                assign w_edge_set[gi] = w_accept[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= RST_LEVEL;
        end else begin
            r_stable <= (r_stable & ~w_accept) | (r_sync2 & w_accept);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask <= '0;
        end else if (w_wr && address == ADDR_MASK) begin
            r_irq_mask <= w_wdata;
        end
    end

    assign w_capture_clr = (w_wr && address == ADDR_CAPTURE) ? w_wdata : '0;

    // The set term is ORed in after the clear so a new edge beats a clear on the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_capture <= '0;
        end else begin
            r_edge_capture <= (r_edge_capture & ~w_capture_clr) | w_edge_set;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = r_stable;
            ADDR_MASK:    readdata[WIDTH-1:0] = r_irq_mask;
            ADDR_CAPTURE: readdata[WIDTH-1:0] = r_edge_capture;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_nios_system_gpio_in.sv
// Directed bench: instance a is rising-edge/idle-low, instance b is falling-edge/idle-high.
`timescale 1ns/1ps
module tb_nios_system_gpio_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address_a, address_b;
    logic        chipselect_a, chipselect_b;
    logic        write_n_a, write_n_b;
    logic [31:0] writedata_a, writedata_b;
    logic [31:0] readdata_a, readdata_b;
    logic [7:0]  in_port_a, in_port_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    nios_system_gpio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IDLE_LEVEL(0)) dut_a (
        .clk(clk), .reset(reset), .address(address_a), .chipselect(chipselect_a),
        .write_n(write_n_a), .writedata(writedata_a), .in_port(in_port_a),
        .readdata(readdata_a), .irq(irq_a)
    );

    nios_system_gpio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)) dut_b (
        .clk(clk), .reset(reset), .address(address_b), .chipselect(chipselect_b),
        .write_n(write_n_b), .writedata(writedata_b), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_a(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        address_a = addr;
        #1;
        $display("rd a addr=%0d data=%0h", addr, readdata_a);
        check(tag, readdata_a, exp);
    endtask

    task automatic rd_b(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        address_b = addr;
        #1;
        $display("rd b addr=%0d data=%0h", addr, readdata_b);
        check(tag, readdata_b, exp);
    endtask

    task automatic wr_a(input logic [2:0] addr, input logic [31:0] data);
        $display("wr a addr=%0d data=%0h", addr, data);
        address_a    = addr;
        writedata_a  = data;
        chipselect_a = 1'b1;
        write_n_a    = 1'b0;
        @(posedge clk);
        #1;
        chipselect_a = 1'b0;
        write_n_a    = 1'b1;
        writedata_a  = '0;
    endtask

    task automatic wr_b(input logic [2:0] addr, input logic [31:0] data);
        $display("wr b addr=%0d data=%0h", addr, data);
        address_b    = addr;
        writedata_b  = data;
        chipselect_b = 1'b1;
        write_n_b    = 1'b0;
        @(posedge clk);
        #1;
        chipselect_b = 1'b0;
        write_n_b    = 1'b1;
        writedata_b  = '0;
    endtask

    initial begin
        address_a = '0; address_b = '0;
        chipselect_a = 1'b0; chipselect_b = 1'b0;
        write_n_a = 1'b1; write_n_b = 1'b1;
        writedata_a = '0; writedata_b = '0;
        in_port_a = 8'hFF; in_port_b = 8'hFF;

        // Reset with pins high: idle-low instance must still read zero
        reset = 1'b1;
        tick(2);
        rd_a(3'd0, 32'h0, "rst_data");
        rd_a(3'd2, 32'h0, "rst_mask");
        rd_a(3'd3, 32'h0, "rst_capture");
        check("rst_irq", {31'b0, irq_a}, 32'h0);
        rd_b(3'd0, 32'hFF, "b_rst_data");
        in_port_a = 8'h00;
        reset = 1'b0;
        tick(6);
        rd_a(3'd0, 32'h0, "idle_data");

        // Debounced rise on bit0: visible after E5, not before
        in_port_a = 8'h01;
        tick(1);
        rd_a(3'd0, 32'h0, "rise_e0");
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            rd_a(3'd0, 32'h0, "rise_early");
        end
        tick(1);
        rd_a(3'd0, 32'h01, "rise_e5_data");
        rd_a(3'd3, 32'h01, "rise_e5_capture");
        check("rise_irq_masked", {31'b0, irq_a}, 32'h0);

        // Glitch on bit1 held only three cycles
        wr_a(3'd3, 32'hFF);
        rd_a(3'd3, 32'h0, "clr_capture");
        in_port_a = 8'h03;
        tick(3);
        in_port_a = 8'h01;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            rd_a(3'd0, 32'h01, "glitch_data");
        end
        rd_a(3'd3, 32'h0, "glitch_capture");

        // Interrupt set, clear by capture write, and masking
        wr_a(3'd2, 32'h01);
        rd_a(3'd2, 32'h01, "mask_rd");
        check("irq_no_capture", {31'b0, irq_a}, 32'h0);
        in_port_a = 8'h00;
        tick(8);
        rd_a(3'd3, 32'h0, "fall_not_captured");
        in_port_a = 8'h01;
        tick(5);
        check("irq_before_capture", {31'b0, irq_a}, 32'h0);
        tick(1);
        check("irq_after_capture", {31'b0, irq_a}, 32'h1);
        wr_a(3'd3, 32'h1);
        check("irq_after_clear", {31'b0, irq_a}, 32'h0);
        in_port_a = 8'h00;
        tick(8);
        in_port_a = 8'h01;
        tick(6);
        check("irq_recapture", {31'b0, irq_a}, 32'h1);
        wr_a(3'd2, 32'h0);
        check("irq_unmasked", {31'b0, irq_a}, 32'h0);
        rd_a(3'd3, 32'h01, "capture_kept");

        // Set-wins: clear of bits 1:0 lands on the edge bit0 is captured
        wr_a(3'd3, 32'hFF);
        in_port_a = 8'h03;
        tick(6);
        rd_a(3'd3, 32'h02, "bit1_capture");
        in_port_a = 8'h02;
        tick(8);
        rd_a(3'd3, 32'h02, "bit0_fall_ignored");
        in_port_a = 8'h03;
        tick(5);
        wr_a(3'd3, 32'h3);
        rd_a(3'd3, 32'h01, "set_wins");
        rd_a(3'd0, 32'h03, "set_wins_data");

        // Falling-edge, idle-high instance
        rd_b(3'd5, 32'h0, "b_addr5_idle");
        in_port_b = 8'hFB;
        tick(6);
        rd_b(3'd0, 32'hFB, "b_fall_data");
        rd_b(3'd3, 32'h04, "b_fall_capture");
        rd_b(3'd5, 32'h0, "b_addr5_after_fall");
        in_port_b = 8'hFF;
        tick(6);
        rd_b(3'd0, 32'hFF, "b_rise_data");
        rd_b(3'd3, 32'h04, "b_rise_no_capture");
        wr_b(3'd5, 32'hFFFFFFFF);
        rd_b(3'd5, 32'h0, "b_addr5_write");
        rd_b(3'd2, 32'h0, "b_mask_untouched");
        check("b_irq", {31'b0, irq_b}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
